// File: rtl/spi_regfile_engine.sv
// SPI register-file peripheral: command word (rw + start address), then a burst of
// auto-incrementing data words. Writable low region, read-only region fed from the core.
module spi_regfile_engine #(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 7,
    parameter int                 N_REGS  = 16,
    parameter int                 RO_BASE = 12,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic                                 sclk,
    input  logic                                 rstn,
    input  logic                                 csn,
    input  logic                                 mosi,
    output logic                                 miso,
    input  logic [(N_REGS-RO_BASE)*DATA_W-1:0]   ro_data,
    output logic [RO_BASE*DATA_W-1:0]            reg_q,
    output logic [RO_BASE-1:0]                   wr_strobe,
    output logic [1:0]                           err
);
    localparam int CMD_W = ADDR_W + 1;
    localparam int MAXB  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam int AW1   = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t                          r_state, w_state_nxt;
    logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
    logic [RO_BASE-1:0]              r_strobe;
    logic                            r_miso;
    logic [ADDR_W-1:0]               r_cmd;
    logic [DATA_W-1:0]               r_sh;
    logic                            r_rw;
    logic [ADDR_W-1:0]               r_addr;
    logic [DATA_W-1:0]               r_tx;
    logic [RO_BASE-1:0][DATA_W-1:0]  r_regs;
    logic [1:0]                      r_err;
    logic                            r_partial;

    logic                            w_frame_start, w_cmd_done, w_word_done;
    logic [CMD_W-1:0]                w_cmd_full;
    logic [ADDR_W-1:0]               w_addr_inc, w_rd_addr;
    logic [DATA_W-1:0]               w_word, w_rd_word, w_tx_sh;
    logic [RO_BASE-1:0]              w_wr_sel;
    logic                            w_wr_ok;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_frame_start = 1'b0;
        w_cmd_done    = 1'b0;
        w_word_done   = 1'b0;
        if (csn) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt   = S_CMD;
                    w_cnt_nxt     = CNT_W'(1);
                    w_frame_start = 1'b1;
                end
                S_CMD: begin
                    if (r_cnt == CNT_W'(CMD_W - 1)) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                        w_cmd_done  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_cnt_nxt   = '0;
                        w_word_done = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_cmd_full = {r_cmd, mosi};
    assign w_word     = DATA_W'({r_sh, mosi});
    // Wrap at the top of the populated map; out-of-range addresses wrap naturally at 2**ADDR_W.
    assign w_addr_inc = (r_addr == ADDR_W'(N_REGS - 1)) ? '0 : r_addr + ADDR_W'(1);
    assign w_rd_addr  = w_cmd_done ? w_cmd_full[ADDR_W-1:0] : w_addr_inc;
    assign w_wr_ok    = {1'b0, r_addr} < AW1'(RO_BASE);

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < RO_BASE; i++)
            if (w_rd_addr == ADDR_W'(i)) w_rd_word = r_regs[i];
        for (int i = RO_BASE; i < N_REGS; i++)
            if (w_rd_addr == ADDR_W'(i)) w_rd_word = ro_data[(i-RO_BASE)*DATA_W +: DATA_W];
    end

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < RO_BASE; i++)
            w_wr_sel[i] = w_word_done && r_rw && (r_addr == ADDR_W'(i));
    end

    // Frame state: csn high clears it asynchronously, registers and errors survive.
    always_ff @(posedge sclk or negedge rstn or posedge csn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_strobe <= '0;
        end else if (csn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_strobe <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_strobe <= w_wr_sel;
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_regs    <= {RO_BASE{RST_VAL}};
            r_err     <= '0;
            r_partial <= 1'b0;
            r_cmd     <= '0;
            r_sh      <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_tx      <= '0;
        end else begin
            r_partial <= (w_cnt_nxt != '0) || (w_state_nxt == S_CMD);
            if (w_frame_start)
                r_err[0] <= r_err[0] | r_partial;
            if (!csn && r_state != S_DATA)
                r_cmd <= ADDR_W'({r_cmd, mosi});
            if (!csn && r_state == S_DATA)
                r_sh <= w_word;
            if (w_cmd_done) begin
                r_rw   <= w_cmd_full[CMD_W-1];
                r_addr <= w_cmd_full[ADDR_W-1:0];
            end
            if (w_word_done)
                r_addr <= w_addr_inc;
            // Next read word is fetched on the edge that finishes the command or previous word.
            if ((w_cmd_done && !w_cmd_full[CMD_W-1]) || (w_word_done && !r_rw))
                r_tx <= w_rd_word;
            if (w_word_done && r_rw && !w_wr_ok)
                r_err[1] <= 1'b1;
            for (int i = 0; i < RO_BASE; i++)
                if (w_wr_sel[i]) r_regs[i] <= w_word;
        end
    end

    assign w_tx_sh = r_tx << r_cnt;

    always_ff @(negedge sclk or negedge rstn or posedge csn) begin
        if (!rstn)
            r_miso <= 1'b0;
        else if (csn)
            r_miso <= 1'b0;
        else
            r_miso <= (r_state == S_DATA) ? w_tx_sh[DATA_W-1] : 1'b0;
    end

    assign miso      = r_miso;
    assign reg_q     = r_regs;
    assign wr_strobe = r_strobe;
    assign err       = r_err;

endmodule

// File: doc/spi_regfile_engine.md
# spi_regfile_engine

- Parametrised SPI register-file peripheral, successor to the fixed 8-bit special-register SPI path.
- Decodes a command word from the serial stream, then streams any number of data words, auto-incrementing the address after each word.
- Holds N_REGS registers: a writable region `[0, RO_BASE)` and a read-only region `[RO_BASE, N_REGS)` sampled from core status inputs.
- Sits between the chip pads (sclk/csn/mosi/miso) and the core configuration/status nets; everything runs in the sclk domain.

## Interface
Parameters:
- DATA_W, 8, bits per register/data word (≥2)
- ADDR_W, 7, address bits in the command word; command width CMD_W = ADDR_W+1
- N_REGS, 16, total registers (≤ 2**ADDR_W)
- RO_BASE, 12, first read-only address (0 < RO_BASE ≤ N_REGS)
- RST_VAL, 0, reset value of every writable register

Ports:
- sclk  in  1  serial clock; the only clock
- rstn  in  1  reset, asynchronous, active-low
- csn  in  1  chip select, active-low; high asynchronously clears frame state only
- mosi  in  1  serial data in, MSB first, sampled on sclk rising edge
- miso  out  1  serial data out, MSB first, launched on sclk falling edge
- ro_data  in  (N_REGS-RO_BASE)*DATA_W  read-only register sources; slice i maps to address RO_BASE+i
- reg_q  out  RO_BASE*DATA_W  writable register contents; slice i is address i
- wr_strobe  out  RO_BASE  one-sclk-cycle pulse per written address
- err  out  2  sticky: [0] truncated frame, [1] illegal write

## Operation
- Reset (rstn low): reg_q = RST_VAL in all slices, wr_strobe = 0, miso = 0, err = 0, state IDLE, all counters 0, partial flag 0.
- csn high: forces IDLE, bit counter 0 and wr_strobe 0, and holds miso at 0. Does not touch reg_q, err or the partial flag.
- States:
  - IDLE: on the first rising edge with csn low, capture the command bit and go to CMD.
  - CMD: shift CMD_W bits. Bit CMD_W-1 is rw (1 = write); the low ADDR_W bits are the start address.
  - DATA: repeat DATA_W-bit words until csn rises.
- Write word completes on the rising edge of its last bit:
  - If addr < RO_BASE: register addr takes the shifted word on that edge, and wr_strobe[addr] is 1 until the next rising edge.
  - Otherwise the word is discarded and err[1] is set.
- Read word:
  - Loaded into the tx register on the rising edge of the last command bit (first word) or of the previous word's last bit (later words).
  - Source: writable reg, ro_data slice (sampled at the load edge), or all-zeros if addr ≥ N_REGS.
  - miso on each falling edge in DATA = tx[DATA_W-1-bitcnt].
  - During a read frame, mosi data bits are ignored.
- Address increments by 1 after each completed word and wraps from N_REGS-1 to 0. An out-of-range start address increments unchanged until it wraps at 2**ADDR_W.
- Truncation:
  - partial flag (rstn-only reset) is updated every rising edge to "bit counter nonzero after this edge, or state CMD".
  - On the IDLE→CMD edge of the next frame, err[0] |= partial.
  - A truncated word is never written.
- err clears only on rstn.

## Timing
- Write latency: register value and wr_strobe update on the rising edge of the word's last bit.
- Read latency:
  - First read MSB is on miso after the falling edge following the last command bit, so the master samples it on the next rising edge.
  - This gives zero turnaround bits.
- Back-to-back words have no gap bits.
- wr_strobe is held if sclk stops, and cleared by csn high.
- Simultaneous events:
  - csn rising together with the last-bit edge: the word counts only if the rising sclk edge precedes csn.
  - rstn overrides everything.
- In DATA, miso changes only on falling edges.

## Test plan
- Reset: rstn low with defaults → reg_q all 0, err=00, miso=0, wr_strobe=0.
- Burst write: cmd 0x83 then 0xA5, 0x5A → reg3=0xA5, reg4=0x5A; wr_strobe[3] then wr_strobe[4], each 1 cycle.
- Burst read with wrap and read-only region:
  - Setup: regs 14, 15 readable, ro_data slice 2 = 0x3C, slice 3 = 0xC3.
  - Stimulus: cmd 0x0E, 3 words.
  - Response: miso 0x3C, 0xC3, then reg0.
  - Also check the MSB of 0x3C appears one falling edge after the command.
- Illegal write: cmd 0x8D (read-only address 13), data 0xFF → no reg change, no strobe, err[1]=1.
- Truncation: cmd 0x81, 5 data bits, csn high → reg1 unchanged. Next frame's first edge → err[0]=1.
- Reset mid-frame: rstn low during bit 4 of a write to reg2 → all outputs at reset values. A fresh frame then writes normally.
